// File: rtl/weight_serializer_pkg.sv
// Shared types and constants for the serial weight-load transmitter.
// Holds the FSM state enum, CRC-16/CCITT constants and a ceil_div helper.
package weight_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_e;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/crc16_serial.sv
// Bit-serial CRC-16/CCITT (MSB-first register, no reflection).
// Ports: clk, rst (sync, active-high), init, en, bit_in, crc[15:0].
module crc16_serial
  import weight_serializer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic        bit_in,
  output logic [15:0] crc
);

  logic [15:0] crc_q;
  logic        fb;

  assign fb  = crc_q[15] ^ bit_in;
  assign crc = crc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= CRC16_INIT;
    end else if (init) begin
      crc_q <= CRC16_INIT;
    end else if (en) begin
      crc_q <= {crc_q[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    end
  end

endmodule

// File: rtl/weight_serializer.sv
// Streams host weight words LSB-first onto the model's copy/k shift port.
// Ports: clk, rst, start, s_valid/s_data/s_ready (host stream), k, copy,
// busy, done; crc[15:0] only when WEIGHT_SERIALIZER_CRC_EN is defined.
module weight_serializer
  import weight_serializer_pkg::*;
#(
  parameter int WEIGHTS_B = 12864,
  parameter int W         = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         s_valid,
  input  logic [W-1:0] s_data,
  output logic         s_ready,
  output logic         k,
  output logic         copy,
  output logic         busy,
  output logic         done
`ifdef WEIGHT_SERIALIZER_CRC_EN
  ,
  output logic [15:0]  crc
`endif
);

  localparam int TW = (WEIGHTS_B > 1) ? $clog2(WEIGHTS_B) : 1;
  localparam int BW = $clog2(W);
  localparam logic [TW-1:0] TOT_LAST = TW'(WEIGHTS_B - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);

  state_e        state_q;
  logic [BW-1:0] bit_cnt_q;
  logic [TW-1:0] tot_cnt_q;
  logic [W-1:0]  shreg_q;
  logic          k_q;
  logic          copy_q;
  logic          busy_q;
  logic          done_q;

  logic last_bit;
  logic word_end;
  logic hs;

  // Counters index the bit currently presented on k.
  assign last_bit = (tot_cnt_q == TOT_LAST);
  assign word_end = (bit_cnt_q == BIT_LAST);

  always_comb begin
    s_ready = 1'b0;
    unique case (state_q)
      LOAD:    s_ready = 1'b1;
      SHIFT:   s_ready = word_end && !last_bit;
      default: s_ready = 1'b0;
    endcase
  end

  assign hs   = s_valid && s_ready;
  assign k    = k_q;
  assign copy = copy_q;
  assign busy = busy_q;
  assign done = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      tot_cnt_q <= '0;
      shreg_q   <= '0;
      k_q       <= 1'b0;
      copy_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= LOAD;
            busy_q    <= 1'b1;
            bit_cnt_q <= '0;
            tot_cnt_q <= '0;
          end
        end
        LOAD: begin
          if (hs) begin
            state_q   <= SHIFT;
            k_q       <= s_data[0];
            shreg_q   <= s_data >> 1;
            bit_cnt_q <= '0;
            copy_q    <= 1'b1;
          end
        end
        SHIFT: begin
          if (last_bit) begin
            // Stops mid-word on a partial last word.
            state_q <= DONE;
            k_q     <= 1'b0;
            copy_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (word_end) begin
            tot_cnt_q <= tot_cnt_q + 1'b1;
            if (hs) begin
              k_q       <= s_data[0];
              shreg_q   <= s_data >> 1;
              bit_cnt_q <= '0;
            end else begin
              state_q <= LOAD;
              k_q     <= 1'b0;
              copy_q  <= 1'b0;
            end
          end else begin
            k_q       <= shreg_q[0];
            shreg_q   <= shreg_q >> 1;
            bit_cnt_q <= bit_cnt_q + 1'b1;
            tot_cnt_q <= tot_cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef WEIGHT_SERIALIZER_CRC_EN
  crc16_serial u_crc (
    .clk    (clk),
    .rst    (rst),
    .init   ((state_q == IDLE) && start),
    .en     (copy_q),
    .bit_in (k_q),
    .crc    (crc)
  );
`endif

endmodule

// File: tb/tb_weight_serializer.sv
// Scoreboard bench for weight_serializer (WEIGHTS_B=40, W=16).
// Random weight vectors, stalls, ignored starts and a mid-load reset.
module tb_weight_serializer;

  localparam int WB = 40;
  localparam int W  = 16;
  localparam int NW = weight_serializer_pkg::ceil_div(WB, W);

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         s_valid;
  logic [W-1:0] s_data;
  logic         s_ready;
  logic         k;
  logic         copy;
  logic         busy;
  logic         done;
`ifdef WEIGHT_SERIALIZER_CRC_EN
  logic [15:0]  crc;
`endif

  weight_serializer #(.WEIGHTS_B(WB), .W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_ready (s_ready),
    .k       (k),
    .copy    (copy),
    .busy    (busy),
    .done    (done)
`ifdef WEIGHT_SERIALIZER_CRC_EN
    ,
    .crc     (crc)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  bit            exp_bits[$];
  int            exp_runs[$];
  logic [WB-1:0] exp_vec[$];
  logic [15:0]   exp_crc[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference CRC-16/CCITT over the vector in emission order (bit 0 first).
  function automatic logic [15:0] crc_model(input logic [WB-1:0] v);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < WB; i++) begin
      if (c[15] ^ v[i]) c = (c << 1) ^ 16'h1021;
      else c = c << 1;
    end
    return c;
  endfunction

  // Monitor: one expected bit per copy cycle, load totals at done.
  initial begin : monitor
    int            copies;
    int            runs;
    int            hs;
    bit            prev_copy;
    logic [WB-1:0] wmod;
    copies    = 0;
    runs      = 0;
    hs        = 0;
    prev_copy = 1'b0;
    wmod      = '0;
    forever begin
      @(negedge clk);
      if (copy === 1'b1) begin
        if (exp_bits.size() == 0) chk("extra_bit", 64'(k), 64'(2));
        else chk("k_bit", 64'(k), 64'(exp_bits.pop_front()));
        if (!prev_copy) runs++;
        copies++;
        wmod = {k, wmod[WB-1:1]};
      end
      if (s_valid && s_ready) hs++;
      if (done === 1'b1) begin
        if (exp_vec.size() == 0) begin
          chk("spurious_done", 64'(1), 64'(0));
        end else begin
          chk("copy_count", 64'(copies), 64'(WB));
          chk("handshakes", 64'(hs), 64'(NW));
          chk("copy_runs", 64'(runs), 64'(exp_runs.pop_front()));
          chk("weights", 64'(wmod), 64'(exp_vec.pop_front()));
          chk("done_after_last", 64'(prev_copy), 64'(1));
          chk("busy_at_done", 64'(busy), 64'(0));
`ifdef WEIGHT_SERIALIZER_CRC_EN
          chk("crc", 64'(crc), 64'(exp_crc.pop_front()));
`endif
        end
        copies = 0;
        runs   = 0;
        hs     = 0;
      end
      if (rst === 1'b1) begin
        exp_bits.delete();
        exp_runs.delete();
        exp_vec.delete();
        exp_crc.delete();
        copies = 0;
        runs   = 0;
        hs     = 0;
      end
      prev_copy = (copy === 1'b1);
    end
  end

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic push_expect(input logic [WB-1:0] vec, input int nruns);
    for (int i = 0; i < WB; i++) exp_bits.push_back(vec[i]);
    exp_runs.push_back(nruns);
    exp_vec.push_back(vec);
    exp_crc.push_back(crc_model(vec));
  endtask

  task automatic make_pad(input logic [WB-1:0] vec,
                          output logic [NW*W-1:0] pad);
    pad = {(NW*W-WB)'($urandom), vec};
  endtask

  task automatic send_word(input logic [W-1:0] wd);
    bit ok;
    s_valid = 1'b1;
    s_data  = wd;
    wait_ready(ok);
    if (!ok) chk("ready_timeout", 64'(0), 64'(1));
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_data  = W'($urandom);
  endtask

  task automatic run_load(input logic [WB-1:0] vec, input int stall1,
                          input bit mid_start);
    logic [NW*W-1:0] pad;
    bit ok;
    make_pad(vec, pad);
    push_expect(vec, (stall1 > 0) ? 2 : 1);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int w = 0; w < NW; w++) begin
      if (w == 1 && stall1 > 0) begin
        wait_ready(ok);
        if (!ok) chk("stall_timeout", 64'(0), 64'(1));
        repeat (stall1) begin
          @(posedge clk);
          #1;
        end
      end
      send_word(pad[w*W +: W]);
      if (mid_start && w == 1) begin
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
    end
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("done_timeout", 64'(0), 64'(1));
    @(posedge clk);
    #1;
  endtask

  initial begin : driver
    logic [WB-1:0]   vec;
    logic [NW*W-1:0] pad;
    rst     = 1'b1;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_copy", 64'(copy), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_k", 64'(k), 64'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_ready", 64'(s_ready), 64'(0));

    vec = {8'h81, 16'h0F0F, 16'hA5C3};
    run_load(vec, 0, 1'b0);
    run_load(vec, 5, 1'b0);

    for (int n = 0; n < 8; n++) begin
      vec = {8'($urandom), 32'($urandom)};
      run_load(vec, (n % 2 == 1) ? int'($urandom_range(1, 4)) : 0,
               (n % 3 == 0));
      chk("busy_after_done", 64'(busy), 64'(0));
    end

    // s_valid held in IDLE must not be accepted.
    s_valid = 1'b1;
    s_data  = W'($urandom);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("ready_in_idle", 64'(s_ready), 64'(0));
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;

    // Reset while bit 20 is on k.
    vec = {8'($urandom), 32'($urandom)};
    make_pad(vec, pad);
    push_expect(vec, 1);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    send_word(pad[0 +: W]);
    send_word(pad[W +: W]);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk("pre_rst_copy", 64'(copy), 64'(1));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_copy", 64'(copy), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_ready", 64'(s_ready), 64'(0));
    @(posedge clk);
    #1;

    vec = {8'($urandom), 32'($urandom)};
    run_load(vec, 0, 1'b0);

    repeat (3) @(posedge clk);
    chk("leftover_bits", 64'(exp_bits.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
